// File: rtl/dhcp_vlg_lease_tmr_if.sv
// DHCP lease timer bus: ACK lease fields and release from the DHCP core,
// renew/rebind/expiry requests and lease status back to the core and the
// request generator.
interface dhcp_vlg_lease_tmr_if #(
  parameter int TIME_W = 32
);
  logic              lease_val;
  logic [TIME_W-1:0] lease_time;
  logic              t1_pres;
  logic [TIME_W-1:0] t1_time;
  logic              t2_pres;
  logic [TIME_W-1:0] t2_time;
  // "release" is a reserved word in SystemVerilog, hence the prefix.
  logic              lease_release;
  logic              renew_req;
  logic              rebind_req;
  logic              expired;
  logic              bound;
  logic [1:0]        phase;
  logic [TIME_W-1:0] remaining;

  modport master (
    output lease_val, lease_time, t1_pres, t1_time, t2_pres, t2_time, lease_release,
    input  renew_req, rebind_req, expired, bound, phase, remaining
  );

  modport slave (
    input  lease_val, lease_time, t1_pres, t1_time, t2_pres, t2_time, lease_release,
    output renew_req, rebind_req, expired, bound, phase, remaining
  );
endinterface

// File: rtl/dhcp_vlg_lease_tmr.sv
// DHCP client lease timer. Counts lease seconds from the core clock and
// issues renew (T1) and rebind (T2) requests with periodic retransmit,
// plus an expiry pulse when the lease runs out.
// Optional feature macro: DHCP_VLG_LEASE_INFINITE_EN -- an all-ones
// lease_time is treated as an infinite lease (no counting, no events).
module dhcp_vlg_lease_tmr #(
  parameter int REFCLK_HZ = 125000000,
  parameter int TIME_W    = 32,
  parameter int RETRY_S   = 60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dhcp_vlg_lease_tmr_if.slave  bus
);

  localparam int PW = (REFCLK_HZ > 1) ? $clog2(REFCLK_HZ) : 1;
  localparam int RW = (RETRY_S > 1) ? $clog2(RETRY_S + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFCLK_HZ - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_S);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_BOUND  = 2'd1,
    PH_RENEW  = 2'd2,
    PH_REBIND = 2'd3
  } phase_e;

  // Default T1 is half the lease.
  function automatic logic [TIME_W-1:0] dflt_t1(input logic [TIME_W-1:0] l);
    return l >> 1;
  endfunction

  // Default T2 is 7/8 of the lease, formed without widening.
  function automatic logic [TIME_W-1:0] dflt_t2(input logic [TIME_W-1:0] l);
    return l - (l >> 3);
  endfunction

  phase_e            phase_r, nxt_phase_s;
  logic [TIME_W-1:0] lease_r, t1_r, t2_r, elapsed_r;
  logic [PW-1:0]     presc_r;
  logic [RW-1:0]     retry_r;
  logic              inf_r;
  logic              renew_req_r, rebind_req_r, expired_r;

  logic [TIME_W-1:0] t1_sel_s, t2_sel_s, t1_ld_s, t2_ld_s;
  logic [TIME_W-1:0] elap_inc_s, remaining_s;
  logic [RW-1:0]     retry_inc_s;
  logic              tick_s, inf_ld_s, bound_s;
  logic              ev_renew_s, ev_rebind_s, ev_expire_s, retry_clr_s;

`ifdef DHCP_VLG_LEASE_INFINITE_EN
  assign inf_ld_s = &bus.lease_time;
`else
  assign inf_ld_s = 1'b0;
`endif

  // One-second tick: only while a finite lease is being tracked.
  assign tick_s      = (phase_r != PH_IDLE) && !inf_r && (presc_r == PRESC_MAX);
  assign elap_inc_s  = (elapsed_r == lease_r) ? elapsed_r : elapsed_r + TIME_W'(1);
  assign retry_inc_s = retry_r + RW'(1);

  // Pick T1/T2 from options, falling back to defaults when inconsistent.
  always_comb begin
    t1_sel_s = bus.t1_pres ? bus.t1_time : dflt_t1(bus.lease_time);
    t2_sel_s = bus.t2_pres ? bus.t2_time : dflt_t2(bus.lease_time);
    if ((t1_sel_s > t2_sel_s) || (t2_sel_s > bus.lease_time)) begin
      t1_ld_s = dflt_t1(bus.lease_time);
      t2_ld_s = dflt_t2(bus.lease_time);
    end else begin
      t1_ld_s = t1_sel_s;
      t2_ld_s = t2_sel_s;
    end
  end

  // Phase state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r <= PH_IDLE;
    end else begin
      phase_r <= nxt_phase_s;
    end
  end

  // Next phase and event decode: release, then new lease, then tick events
  // (expiry over T2 over T1 over retransmit).
  always_comb begin
    nxt_phase_s = phase_r;
    ev_renew_s  = 1'b0;
    ev_rebind_s = 1'b0;
    ev_expire_s = 1'b0;
    retry_clr_s = 1'b0;
    if (bus.lease_release) begin
      nxt_phase_s = PH_IDLE;
    end else if (bus.lease_val) begin
      if (bus.lease_time == '0) begin
        nxt_phase_s = PH_IDLE;
        ev_expire_s = 1'b1;
      end else begin
        nxt_phase_s = PH_BOUND;
      end
    end else if (tick_s) begin
      if (elap_inc_s == lease_r) begin
        nxt_phase_s = PH_IDLE;
        ev_expire_s = 1'b1;
      end else if ((elap_inc_s >= t2_r) && (phase_r != PH_REBIND)) begin
        nxt_phase_s = PH_REBIND;
        ev_rebind_s = 1'b1;
        retry_clr_s = 1'b1;
      end else if ((elap_inc_s >= t1_r) && (phase_r == PH_BOUND)) begin
        nxt_phase_s = PH_RENEW;
        ev_renew_s  = 1'b1;
        retry_clr_s = 1'b1;
      end else begin
        case (phase_r)
          PH_RENEW: begin
            if (retry_inc_s == RETRY_MAX) begin
              ev_renew_s  = 1'b1;
              retry_clr_s = 1'b1;
            end else begin
              retry_clr_s = 1'b0;
            end
          end
          PH_REBIND: begin
            if (retry_inc_s == RETRY_MAX) begin
              ev_rebind_s = 1'b1;
              retry_clr_s = 1'b1;
            end else begin
              retry_clr_s = 1'b0;
            end
          end
          default: begin
            retry_clr_s = 1'b1;
          end
        endcase
      end
    end else begin
      nxt_phase_s = phase_r;
    end
  end

  // Lease registers, counters and registered request/expiry pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lease_r      <= '0;
      t1_r         <= '0;
      t2_r         <= '0;
      elapsed_r    <= '0;
      presc_r      <= '0;
      retry_r      <= '0;
      inf_r        <= 1'b0;
      renew_req_r  <= 1'b0;
      rebind_req_r <= 1'b0;
      expired_r    <= 1'b0;
    end else begin
      renew_req_r  <= ev_renew_s;
      rebind_req_r <= ev_rebind_s;
      expired_r    <= ev_expire_s;
      if (bus.lease_release || ev_expire_s) begin
        lease_r   <= '0;
        t1_r      <= '0;
        t2_r      <= '0;
        elapsed_r <= '0;
        presc_r   <= '0;
        retry_r   <= '0;
        inf_r     <= 1'b0;
      end else if (bus.lease_val) begin
        lease_r   <= bus.lease_time;
        t1_r      <= t1_ld_s;
        t2_r      <= t2_ld_s;
        elapsed_r <= '0;
        presc_r   <= '0;
        retry_r   <= '0;
        inf_r     <= inf_ld_s;
      end else if (tick_s) begin
        presc_r   <= '0;
        elapsed_r <= elap_inc_s;
        retry_r   <= retry_clr_s ? '0 : retry_inc_s;
      end else if ((phase_r != PH_IDLE) && !inf_r) begin
        presc_r <= presc_r + PW'(1);
      end else begin
        presc_r <= presc_r;
      end
    end
  end

  // Lease status derived from registered state.
  always_comb begin
    bound_s = (phase_r != PH_IDLE);
    if (phase_r == PH_IDLE) begin
      remaining_s = '0;
    end else if (inf_r) begin
      remaining_s = '1;
    end else begin
      remaining_s = lease_r - elapsed_r;
    end
  end

  assign bus.renew_req  = renew_req_r;
  assign bus.rebind_req = rebind_req_r;
  assign bus.expired    = expired_r;
  assign bus.bound      = bound_s;
  assign bus.phase      = phase_r;
  assign bus.remaining  = remaining_s;

endmodule

// File: doc/dhcp_vlg_lease_tmr.md
Name: dhcp_vlg_lease_tmr

Overview:
- Tracks the lease obtained by the DHCP client after DORA completes.
- Counts lease time in seconds from the core clock and issues RFC 2131 renew (T1) and rebind (T2) requests, with periodic retransmit, plus an expiry event.
- Sits between the DHCP core, which accepts ACK option fields, and the DHCP request generator.
- Parametrised successor to the fixed DHCP control path: generic clock rate, time width and retry interval.

Parameters:
- REFCLK_HZ, 125000000: clk cycles per one-second tick.
- TIME_W, 32: width of lease, T1, T2 and elapsed counters, in seconds.
- RETRY_S, 60: seconds between retransmitted renew_req/rebind_req within one phase.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- lease_val  in  1  one-cycle pulse; new ACK accepted, load lease fields
- lease_time  in  TIME_W  option 51 lease time, s
- t1_pres  in  1  option 58 present
- t1_time  in  TIME_W  option 58 value, s
- t2_pres  in  1  option 59 present
- t2_time  in  TIME_W  option 59 value, s
- release  in  1  pulse; abandon lease
- renew_req  out  1  pulse; send unicast REQUEST
- rebind_req  out  1  pulse; send broadcast REQUEST
- expired  out  1  pulse; lease lost, IP invalid
- bound  out  1  level; lease valid
- phase  out  2  0 IDLE, 1 BOUND, 2 RENEWING, 3 REBINDING
- remaining  out  TIME_W  lease_time minus elapsed, s

Behaviour:
- Single clock. Reset is synchronous, active-low: rst_n sampled low on a clk edge clears all state.
- Reset values: all outputs 0, phase IDLE, all counters 0.
- Prescaler counts 0..REFCLK_HZ-1. The tick is asserted in the cycle the prescaler holds REFCLK_HZ-1; the prescaler then wraps to 0. The prescaler runs only in non-IDLE phases.
- On lease_val: register lease L, and T1/T2 as follows:
  - Defaults: T1=L>>1, T2=L-(L>>3), computed at TIME_W width with no overflow.
  - If t1_pres, T1=t1_time. If t2_pres, T2=t2_time.
  - If the resulting T1>T2 or T2>L, both fall back to defaults.
  - Clear elapsed, prescaler and retry counters. Phase becomes BOUND next cycle, from any phase.
- lease_val with lease_time=0: expired pulses next cycle, phase stays IDLE.
- On each tick in a bound phase, elapsed increments and saturates at L. Compares use the new elapsed value, same cycle as the increment. Priority: expiry, then T2, then T1.
  - elapsed==L: expired=1 one cycle, phase IDLE, bound=0.
  - elapsed>=T2 while BOUND or RENEWING: phase REBINDING, rebind_req=1 one cycle, retry counter cleared. No renew_req is issued, so T1==T2 goes directly to REBINDING.
  - elapsed>=T1 while BOUND: phase RENEWING, renew_req=1 one cycle, retry counter cleared.
  - Otherwise, in RENEWING/REBINDING: the retry counter increments on the tick. On reaching RETRY_S it pulses renew_req/rebind_req respectively and clears.
- Requests and expired are single-cycle pulses and never more than one per cycle.
- bound=1 in BOUND, RENEWING and REBINDING. remaining=L-elapsed, combinational from registers; 0 in IDLE.
- release: phase IDLE next cycle, counters cleared, no expired pulse.
- Simultaneous events:
  - release with lease_val: release wins.
  - lease_val with tick: lease_val wins and the tick is discarded.
- rst_n low mid-operation: immediate return to reset values on that edge, with no pulses.

Optional Feature:
- Macro DHCP_VLG_LEASE_INFINITE_EN.
- Defined: lease_time of all ones (0xFFFFFFFF at TIME_W=32) means an infinite lease.
  - Phase BOUND, elapsed and prescaler frozen.
  - remaining is all ones; no renew, rebind or expiry is ever generated.
  - T1/T2 fields are ignored.
- Not defined: all-ones is counted as an ordinary finite lease.

Test Plan:
- REFCLK_HZ=4, RETRY_S=2, lease_val with L=8, no T1/T2 -> T1=4, T2=7.
  - renew_req 16 clk after phase enters BOUND; renew_req again at elapsed 6.
  - rebind_req at elapsed 7; expired at elapsed 8, then phase 0, bound 0, remaining 0.
- Same setup, new lease_val (L=8) at elapsed 5 in RENEWING -> phase 1, remaining 8; next renew_req only at elapsed 4 of the new lease.
- L=20, t1_pres t1_time=10, t2_pres t2_time=5 -> invalid, defaults T1=10, T2=18; renew_req at elapsed 10, rebind_req at 18.
- L=8, T1=T2=6 via options -> only rebind_req at elapsed 6, no renew_req ever, phase 1 to 3.
- release and lease_val same cycle while BOUND -> phase 0 next cycle, no expired pulse. rst_n low during REBINDING -> all outputs 0 next edge.
- With DHCP_VLG_LEASE_INFINITE_EN, L=0xFFFFFFFF -> bound 1 for 1000 ticks, no pulses, remaining 0xFFFFFFFF. Without the macro, remaining decrements by 1 per tick.
